// File: rtl/stack_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : stack_data_mem_responder
// Purpose  : Responder end of the datapath data-memory interface. Serves the
//            read / write / push / pop strobes from the control unit with a
//            request/ack handshake and a configurable response latency.
//            The RAM is word-addressed; its top STACK_DEPTH words hold an
//            upward-growing call/return stack addressed by an internal sp.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH        total RAM words (power of 2)
//   STACK_DEPTH  words reserved for the stack at the top of RAM
//   LATENCY      cycles from request acceptance to ack (>= 1)
// Ports
//   clk          system clock, all state on the rising edge
//   rst          synchronous reset, active-high
//   addr         word address for data ops (ignored for push/pop)
//   wdata        write / push data
//   mem_rd       read request strobe
//   mem_wr       write request strobe
//   push         stack push request strobe
//   pop          stack pop request strobe
//   rdata        read/pop data, valid with ack, held until the next read/pop
//   ack          one-cycle completion pulse
//   busy         a request is outstanding
//   err          qualifies ack: request rejected, no state changed
//   stack_empty  sp == 0
//   stack_full   sp == STACK_DEPTH
//   mem_words    distinct data-region words written since reset
// Configuration macro
//   DMEM_PROTECT_EN  when defined, data reads/writes that land in the stack
//                    region are rejected with err.
// ============================================================================
module stack_data_mem_responder #(
    parameter int DEPTH       = 256,
    parameter int STACK_DEPTH = 32,
    parameter int LATENCY     = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              addr,
    input  logic [31:0]              wdata,
    input  logic                     mem_rd,
    input  logic                     mem_wr,
    input  logic                     push,
    input  logic                     pop,
    output logic [31:0]              rdata,
    output logic                     ack,
    output logic                     busy,
    output logic                     err,
    output logic                     stack_empty,
    output logic                     stack_full,
    output logic [$clog2(DEPTH):0]   mem_words
);

    localparam int AW         = $clog2(DEPTH);
    localparam int WW         = AW + 1;
    localparam int SPW        = $clog2(STACK_DEPTH + 1);
    localparam int CW         = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int DATA_WORDS = DEPTH - STACK_DEPTH;

    localparam logic [AW-1:0]  c_STACK_BASE = AW'(DATA_WORDS);
    localparam logic [SPW-1:0] c_SP_MAX     = SPW'(STACK_DEPTH);
    localparam logic [WW-1:0]  c_WORDS_MAX  = WW'(DATA_WORDS);
    // WAIT spends LATENCY-1 cycles; the counter runs down to zero inclusive.
    localparam logic [CW-1:0]  c_WAIT_INIT  = CW'((LATENCY > 1) ? LATENCY - 2 : 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_opRd;
    logic             r_opWr;
    logic             r_opPush;
    logic             r_opPop;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_rdata;
    logic             r_err;
    logic [SPW-1:0]   r_sp;
    logic [WW-1:0]    r_words;
    logic [DEPTH-1:0] r_written;
    logic [31:0]      r_mem [DEPTH];

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic [1:0]    w_stateNext;
    logic [CW-1:0] w_cntNext;
    logic          w_accept;
    logic          w_commit;
    logic          w_strobeAny;
    logic          w_inIdle;

    logic          w_reqRd;
    logic          w_reqWr;
    logic          w_reqPush;
    logic          w_reqPop;
    logic [31:0]   w_reqAddr;
    logic [31:0]   w_reqWdata;

    logic          w_multi;
    logic          w_addrOob;
    logic [AW-1:0] w_idx;
    logic          w_inStack;
    logic          w_protHit;
    logic [AW-1:0] w_pushIdx;
    logic [AW-1:0] w_popIdx;

    logic          w_memWe;
    logic [AW-1:0] w_memAddr;
    logic [31:0]   w_memData;
    logic          w_rdataLoad;
    logic [31:0]   w_rdataVal;
    logic          w_errSet;
    logic          w_spInc;
    logic          w_spDec;
    logic          w_markWritten;

    assign w_strobeAny = mem_rd | mem_wr | push | pop;
    assign w_inIdle    = (r_state == S_IDLE);

    // With LATENCY==1 the commit happens on the accepting edge itself, so
    // the request is taken straight from the ports; otherwise from the latch.
    assign w_reqRd    = w_inIdle ? mem_rd : r_opRd;
    assign w_reqWr    = w_inIdle ? mem_wr : r_opWr;
    assign w_reqPush  = w_inIdle ? push   : r_opPush;
    assign w_reqPop   = w_inIdle ? pop    : r_opPop;
    assign w_reqAddr  = w_inIdle ? addr   : r_addr;
    assign w_reqWdata = w_inIdle ? wdata  : r_wdata;

    assign w_multi   = ($countones({w_reqRd, w_reqWr, w_reqPush, w_reqPop}) > 1);
    assign w_addrOob = |w_reqAddr[31:AW];
    assign w_idx     = w_reqAddr[AW-1:0];
    assign w_inStack = (w_idx >= c_STACK_BASE);
    assign w_pushIdx = c_STACK_BASE + AW'(r_sp);
    assign w_popIdx  = c_STACK_BASE + AW'(r_sp - SPW'(1));

`ifdef DMEM_PROTECT_EN
    assign w_protHit = w_inStack;
`else
    assign w_protHit = 1'b0;
`endif

    // Handshake FSM: next state and commit timing
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_strobeAny) begin
                    w_accept = 1'b1;
                    if (LATENCY == 1) begin
                        w_stateNext = S_RESP;
                        w_commit    = 1'b1;
                    end else begin
                        w_stateNext = S_WAIT;
                        w_cntNext   = c_WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_stateNext = S_RESP;
                    w_commit    = 1'b1;
                end else begin
                    w_cntNext = r_cnt - CW'(1);
                end
            end
            S_RESP: begin
                w_stateNext = S_IDLE;
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // Request execution, evaluated on the edge that enters RESP
    always_comb begin
        w_memWe       = 1'b0;
        w_memAddr     = w_idx;
        w_memData     = w_reqWdata;
        w_rdataLoad   = 1'b0;
        w_rdataVal    = 32'h0;
        w_errSet      = 1'b0;
        w_spInc       = 1'b0;
        w_spDec       = 1'b0;
        w_markWritten = 1'b0;
        if (w_commit) begin
            if (w_multi) begin
                // Ambiguous request: reject and leave rdata untouched.
                w_errSet = 1'b1;
            end else if (w_reqRd) begin
                w_rdataLoad = 1'b1;
                if (w_addrOob || w_protHit) begin
                    w_errSet = 1'b1;
                end else begin
                    w_rdataVal = r_mem[w_idx];
                end
            end else if (w_reqWr) begin
                if (w_addrOob || w_protHit) begin
                    w_errSet = 1'b1;
                end else begin
                    w_memWe = 1'b1;
                    // Only data-region words count toward mem_words.
                    if (!w_inStack && !r_written[w_idx]) begin
                        w_markWritten = 1'b1;
                    end
                end
            end else if (w_reqPush) begin
                if (r_sp == c_SP_MAX) begin
                    w_errSet = 1'b1;
                end else begin
                    w_memWe   = 1'b1;
                    w_memAddr = w_pushIdx;
                    w_spInc   = 1'b1;
                end
            end else if (w_reqPop) begin
                w_rdataLoad = 1'b1;
                if (r_sp == '0) begin
                    w_errSet = 1'b1;
                end else begin
                    w_rdataVal = r_mem[w_popIdx];
                    w_spDec    = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_opRd    <= 1'b0;
            r_opWr    <= 1'b0;
            r_opPush  <= 1'b0;
            r_opPop   <= 1'b0;
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
            r_rdata   <= 32'h0;
            r_err     <= 1'b0;
            r_sp      <= '0;
            r_words   <= '0;
            r_written <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            if (w_accept) begin
                r_opRd   <= mem_rd;
                r_opWr   <= mem_wr;
                r_opPush <= push;
                r_opPop  <= pop;
                r_addr   <= addr;
                r_wdata  <= wdata;
            end
            if (w_rdataLoad) begin
                r_rdata <= w_rdataVal;
            end
            // err is only ever set on the edge into RESP, so it lasts exactly
            // as long as ack.
            r_err <= w_errSet;
            if (w_spInc) begin
                r_sp <= r_sp + SPW'(1);
            end else if (w_spDec) begin
                r_sp <= r_sp - SPW'(1);
            end
            if (w_markWritten) begin
                r_written[w_idx] <= 1'b1;
                if (r_words != c_WORDS_MAX) begin
                    r_words <= r_words + WW'(1);
                end
            end
        end
    end

    // RAM contents survive reset; a reset edge still blocks a pending write.
    always_ff @(posedge clk) begin
        if (w_memWe && !rst) begin
            r_mem[w_memAddr] <= w_memData;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rdata       = r_rdata;
    assign ack         = (r_state == S_RESP);
    assign busy        = (r_state != S_IDLE);
    assign err         = r_err;
    assign stack_empty = (r_sp == '0);
    assign stack_full  = (r_sp == c_SP_MAX);
    assign mem_words   = r_words;

endmodule
`default_nettype wire

// File: tb/tb_stack_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_stack_data_mem_responder
// Purpose  : Self-checking bench for stack_data_mem_responder. A reference
//            model (plain arrays and a stack pointer) predicts each response
//            when a request is issued; a monitor pops the prediction when ack
//            is seen and compares err, rdata and ack timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stack_data_mem_responder;

    localparam int DEPTH       = 256;
    localparam int STACK_DEPTH = 32;
    localparam int LATENCY     = 3;
    localparam int BASE        = DEPTH - STACK_DEPTH;

    localparam logic [3:0] OP_RD   = 4'b0001;
    localparam logic [3:0] OP_WR   = 4'b0010;
    localparam logic [3:0] OP_PUSH = 4'b0100;
    localparam logic [3:0] OP_POP  = 4'b1000;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [31:0]             addr;
    logic [31:0]             wdata;
    logic                    mem_rd;
    logic                    mem_wr;
    logic                    push;
    logic                    pop;
    logic [31:0]             rdata;
    logic                    ack;
    logic                    busy;
    logic                    err;
    logic                    stack_empty;
    logic                    stack_full;
    logic [$clog2(DEPTH):0]  mem_words;

    always #5 clk = ~clk;

    stack_data_mem_responder #(
        .DEPTH       (DEPTH),
        .STACK_DEPTH (STACK_DEPTH),
        .LATENCY     (LATENCY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .addr        (addr),
        .wdata       (wdata),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .push        (push),
        .pop         (pop),
        .rdata       (rdata),
        .ack         (ack),
        .busy        (busy),
        .err         (err),
        .stack_empty (stack_empty),
        .stack_full  (stack_full),
        .mem_words   (mem_words)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nChecks = 0;
    int nFails  = 0;

    typedef struct {
        bit          err;
        bit          chkData;
        logic [31:0] data;
        int          cycle;
    } exp_t;

    exp_t sb[$];
    exp_t monE;
    bit   monEn = 1'b0;

    // Reference model
    logic [31:0] mMem     [DEPTH];
    bit          mKnown   [DEPTH];
    bit          mWritten [DEPTH];
    int          mSp    = 0;
    int          mWords = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nChecks++;
        if (act !== req) begin
            nFails++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic modelReset();
        mSp    = 0;
        mWords = 0;
        for (int i = 0; i < DEPTH; i++) mWritten[i] = 1'b0;
    endtask

    task automatic modelOp(input logic [3:0] m, input logic [31:0] a,
                           input logic [31:0] d, output exp_t e);
        bit prot;
        e.err     = 1'b0;
        e.chkData = 1'b0;
        e.data    = 32'h0;
        e.cycle   = cyc + LATENCY;
`ifdef DMEM_PROTECT_EN
        prot = (a >= BASE) && (a < DEPTH);
`else
        prot = 1'b0;
`endif
        if ($countones(m) > 1) begin
            e.err = 1'b1;
        end else if (m[0]) begin
            if (a >= DEPTH || prot) begin
                e.err = 1'b1; e.chkData = 1'b1;
            end else begin
                e.chkData = mKnown[a]; e.data = mMem[a];
            end
        end else if (m[1]) begin
            if (a >= DEPTH || prot) begin
                e.err = 1'b1;
            end else begin
                mMem[a] = d; mKnown[a] = 1'b1;
                if (a < BASE && !mWritten[a]) begin
                    mWritten[a] = 1'b1;
                    if (mWords < BASE) mWords++;
                end
            end
        end else if (m[2]) begin
            if (mSp == STACK_DEPTH) begin
                e.err = 1'b1;
            end else begin
                mMem[BASE + mSp] = d; mKnown[BASE + mSp] = 1'b1; mSp++;
            end
        end else if (m[3]) begin
            if (mSp == 0) begin
                e.err = 1'b1; e.chkData = 1'b1;
            end else begin
                mSp--;
                e.chkData = mKnown[BASE + mSp]; e.data = mMem[BASE + mSp];
            end
        end
    endtask

    // Issue one request from an idle negedge and wait for it to complete.
    task automatic issue(input logic [3:0] m, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int   n;
        n = 0;
        while (busy !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        if (n == 50) check("idle_timeout", busy, 0);
        modelOp(m, a, d, e);
        sb.push_back(e);
        mem_rd = m[0]; mem_wr = m[1]; push = m[2]; pop = m[3];
        addr = a; wdata = d;
        @(negedge clk);
        check("busy_after_accept", busy, 1);
        mem_rd = 1'b0; mem_wr = 1'b0; push = 1'b0; pop = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < LATENCY + 10) begin @(negedge clk); n++; end
        if (busy !== 1'b0) check("done_timeout", busy, 0);
        check("stack_empty", stack_empty, mSp == 0);
        check("stack_full", stack_full, mSp == STACK_DEPTH);
        check("mem_words", mem_words, mWords);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (monEn && ack === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", ack, 0);
            end else begin
                monE = sb.pop_front();
                check("ack_cycle", cyc, monE.cycle);
                check("err", err, monE.err);
                if (monE.chkData) check("rdata", rdata, monE.data);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  m;
        logic [31:0] a;
        int          r;

        rst = 1'b1; addr = 32'h0; wdata = 32'h0;
        mem_rd = 1'b0; mem_wr = 1'b0; push = 1'b0; pop = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        modelReset();
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_rdata", rdata, 0);
        check("rst_stack_empty", stack_empty, 1);
        check("rst_stack_full", stack_full, 0);
        check("rst_mem_words", mem_words, 0);
        monEn = 1'b1;

        // Basic write/read
        issue(OP_WR, 32'd5, 32'hDEADBEEF);
        issue(OP_RD, 32'd5, 32'h0);

        // LIFO order and pop underflow
        issue(OP_PUSH, 32'h0, 32'h11);
        issue(OP_PUSH, 32'h0, 32'h22);
        issue(OP_PUSH, 32'h0, 32'h33);
        repeat (4) issue(OP_POP, 32'h0, 32'h0);

        // Fill the stack, then one push too many
        for (int i = 0; i < STACK_DEPTH + 1; i++) issue(OP_PUSH, 32'h0, 32'hA000_0000 + i);
        issue(OP_RD, DEPTH - 1, 32'h0);
        // Direct data write into the top stack slot, then pop it back
        issue(OP_WR, DEPTH - 1, 32'hCAFEF00D);
        issue(OP_POP, 32'h0, 32'h0);
        while (mSp > 0) issue(OP_POP, 32'h0, 32'h0);

        // Illegal combinations and out-of-range address
        issue(OP_RD | OP_PUSH, 32'd7, 32'h5555);
        issue(OP_RD, DEPTH, 32'h0);
        issue(OP_WR, DEPTH + 3, 32'h1234);

        // Reset during WAIT of a push: nothing commits, no ack
        issue(OP_PUSH, 32'h0, 32'h77);
        push = 1'b1; wdata = 32'hBAD0_0001;
        @(negedge clk);
        push = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        check("midrst_busy", busy, 0);
        check("midrst_ack", ack, 0);
        check("midrst_stack_empty", stack_empty, 1);
        check("midrst_rdata", rdata, 0);
        check("midrst_mem_words", mem_words, 0);
        // RAM survives reset; the read must be accepted right away
        issue(OP_RD, 32'd5, 32'h0);

        // Randomized traffic
        repeat (300) begin
            r = $urandom_range(0, 19);
            if (r < 18) m = 4'b0001 << (r % 4);
            else        m = 4'b0011 << $urandom_range(0, 2);
            r = $urandom_range(0, 9);
            if (r < 8)       a = $urandom_range(0, DEPTH - 1);
            else if (r == 8) a = DEPTH + $urandom_range(0, 3);
            else             a = $urandom;
            issue(m, a, $urandom);
        end

        repeat (LATENCY + 4) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire
